// File: rtl/branch_predict_resolve_if.sv
// Fetch/execute bus of the branch unit. The pipeline side is the master and the
// branch unit is the slave.
interface branch_predict_resolve_if #(
    parameter int XLEN   = 32,
    parameter int PERF_W = 16
);
    // fetch side
    logic [XLEN-1:0]   fetch_pc;
    logic              pred_taken;
    logic [XLEN-1:0]   pred_target;
    // execute side
    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc;
    logic [12:0]       ex_imm;
    logic [2:0]        ex_func3;
    logic              z;
    logic              n;
    logic              v;
    logic              c;
    logic              ex_pred_taken;
    logic [XLEN-1:0]   ex_pred_target;
    logic              btb_flush;
    logic              mispredict;
    logic [XLEN-1:0]   redirect_pc;
    logic [PERF_W-1:0] br_count;
    logic [PERF_W-1:0] mp_count;

    modport master (
        output fetch_pc, ex_valid, ex_pc, ex_imm, ex_func3, z, n, v, c,
               ex_pred_taken, ex_pred_target, btb_flush,
        input  pred_taken, pred_target, mispredict, redirect_pc, br_count, mp_count
    );

    modport slave (
        input  fetch_pc, ex_valid, ex_pc, ex_imm, ex_func3, z, n, v, c,
               ex_pred_taken, ex_pred_target, btb_flush,
        output pred_taken, pred_target, mispredict, redirect_pc, br_count, mp_count
    );
endinterface

// File: rtl/branch_predict_resolve.sv
// Branch unit: direct-mapped BTB with saturating counters for zero-latency fetch
// prediction, plus EX-stage resolution, BTB training and a registered redirect.
module branch_predict_resolve #(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 16,
    parameter int CTR_W       = 2,
    parameter int PERF_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_predict_resolve_if.slave bp
);
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam logic [CTR_W-1:0]  CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0]  CTR_ZERO = {CTR_W{1'b0}};
    localparam logic [CTR_W-1:0]  CTR_RST  = CTR_W'(1);
    // weakly taken: only the MSB set
    localparam logic [CTR_W-1:0]  CTR_WT   = CTR_W'(1) << (CTR_W - 1);
    localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

    // BTB storage
    logic [BTB_ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]       r_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]        r_target [BTB_ENTRIES];
    logic [CTR_W-1:0]       r_ctr    [BTB_ENTRIES];

    logic              r_mispredict;
    logic [XLEN-1:0]   r_redirect_pc;
    logic [PERF_W-1:0] r_br_count;
    logic [PERF_W-1:0] r_mp_count;

    logic [IDX_W-1:0] w_f_idx;
    logic [TAG_W-1:0] w_f_tag;
    logic             w_f_hit;
    logic             w_pred_taken;
    logic [XLEN-1:0]  w_pred_target;

    logic [IDX_W-1:0] w_e_idx;
    logic [TAG_W-1:0] w_e_tag;
    logic             w_e_hit;
    logic             w_taken;
    logic             w_legal;
    logic [XLEN-1:0]  w_offset;
    logic [XLEN-1:0]  w_tgt;
    logic [XLEN-1:0]  w_next;
    logic             w_mp;
    logic             w_train;
    logic             w_upd_hit;
    logic             w_alloc;
    logic [CTR_W-1:0] w_ctr_next;
    logic             w_unused;

    // the offset is always even, so bit 0 of the immediate carries no information
    assign w_unused = bp.ex_imm[0];

    assign w_f_idx = bp.fetch_pc[IDX_W+1:2];
    assign w_f_tag = bp.fetch_pc[XLEN-1:IDX_W+2];
    assign w_e_idx = bp.ex_pc[IDX_W+1:2];
    assign w_e_tag = bp.ex_pc[XLEN-1:IDX_W+2];

    // fetch lookup reads the array as it stands before this edge: no training bypass
    always_comb begin
        w_f_hit       = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
        w_pred_taken  = w_f_hit & r_ctr[w_f_idx][CTR_W-1];
        if (w_pred_taken) begin
            w_pred_target = r_target[w_f_idx];
        end else begin
            w_pred_target = bp.fetch_pc + XLEN'(4);
        end
    end

    // branch condition from ALU flags of rs1-rs2; 010/011 are illegal and never train
    always_comb begin
        w_taken = 1'b0;
        w_legal = 1'b1;
        case (bp.ex_func3)
            3'b000:  w_taken = bp.z;
            3'b001:  w_taken = ~bp.z;
            3'b100:  w_taken = bp.n ^ bp.v;
            3'b101:  w_taken = ~(bp.n ^ bp.v);
            3'b110:  w_taken = ~bp.c;
            3'b111:  w_taken = bp.c;
            default: begin
                w_taken = 1'b0;
                w_legal = 1'b0;
            end
        endcase
    end

    // target, next PC, mispredict detect and training decisions
    always_comb begin
        w_offset = {{(XLEN-13){bp.ex_imm[12]}}, bp.ex_imm[12:1], 1'b0};
        w_tgt    = bp.ex_pc + w_offset;
        if (w_taken) begin
            w_next = w_tgt;
        end else begin
            w_next = bp.ex_pc + XLEN'(4);
        end
        w_mp      = bp.ex_valid & ((w_taken != bp.ex_pred_taken) |
                                   (w_taken & (bp.ex_pred_target != w_tgt)));
        w_e_hit   = r_valid[w_e_idx] && (r_tag[w_e_idx] == w_e_tag);
        // a flush in the same cycle wins over any training
        w_train   = bp.ex_valid & w_legal & ~bp.btb_flush;
        w_upd_hit = w_train & w_e_hit;
        w_alloc   = w_train & ~w_e_hit & w_taken;
        if (w_taken) begin
            w_ctr_next = (r_ctr[w_e_idx] == CTR_MAX) ? CTR_MAX : r_ctr[w_e_idx] + CTR_W'(1);
        end else begin
            w_ctr_next = (r_ctr[w_e_idx] == CTR_ZERO) ? CTR_ZERO : r_ctr[w_e_idx] - CTR_W'(1);
        end
    end

    // valid bits and predictor counters (reset to invalid / weakly not-taken)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int k = 0; k < BTB_ENTRIES; k++) begin
                r_ctr[k] <= CTR_RST;
            end
        end else begin
            if (bp.btb_flush) begin
                r_valid <= '0;
            end else if (w_alloc) begin
                r_valid[w_e_idx] <= 1'b1;
            end
            if (w_upd_hit) begin
                r_ctr[w_e_idx] <= w_ctr_next;
            end else if (w_alloc) begin
                r_ctr[w_e_idx] <= CTR_WT;
            end
        end
    end

    // tag/target storage; never read while invalid, so it carries no reset
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_tag[w_e_idx]    <= w_e_tag;
            r_target[w_e_idx] <= w_tgt;
        end else if (w_upd_hit && w_taken) begin
            r_target[w_e_idx] <= w_tgt;
        end
    end

    // one-cycle redirect pulse; redirect PC holds between mispredicts
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mispredict  <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_mispredict <= w_mp;
            if (w_mp) begin
                r_redirect_pc <= w_next;
            end
        end
    end

    // saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_br_count <= '0;
            r_mp_count <= '0;
        end else begin
            if (bp.ex_valid && (r_br_count != PERF_MAX)) begin
                r_br_count <= r_br_count + PERF_W'(1);
            end
            if (w_mp && (r_mp_count != PERF_MAX)) begin
                r_mp_count <= r_mp_count + PERF_W'(1);
            end
        end
    end

    assign bp.pred_taken  = w_pred_taken;
    assign bp.pred_target = w_pred_target;
    assign bp.mispredict  = r_mispredict;
    assign bp.redirect_pc = r_redirect_pc;
    assign bp.br_count    = r_br_count;
    assign bp.mp_count    = r_mp_count;
endmodule

// File: tb/tb_branch_predict_resolve.sv
// Bench for branch_predict_resolve: directed vector table, hand-written perf/reset
// sequences, and random traffic against a behavioural BTB model.
module tb_branch_predict_resolve;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_predict_resolve_if #(.XLEN(32), .PERF_W(16)) bus ();
    branch_predict_resolve_if #(.XLEN(32), .PERF_W(4))  bus4 ();

    branch_predict_resolve #(.XLEN(32), .BTB_ENTRIES(16), .CTR_W(2), .PERF_W(16)) dut (
        .clk(clk), .rst(rst), .bp(bus.slave));
    branch_predict_resolve #(.XLEN(32), .BTB_ENTRIES(16), .CTR_W(2), .PERF_W(4)) dut4 (
        .clk(clk), .rst(rst), .bp(bus4.slave));

    // the narrow-counter instance sees identical traffic
    assign bus4.fetch_pc       = bus.fetch_pc;
    assign bus4.ex_valid       = bus.ex_valid;
    assign bus4.ex_pc          = bus.ex_pc;
    assign bus4.ex_imm         = bus.ex_imm;
    assign bus4.ex_func3       = bus.ex_func3;
    assign bus4.z              = bus.z;
    assign bus4.n              = bus.n;
    assign bus4.v              = bus.v;
    assign bus4.c              = bus.c;
    assign bus4.ex_pred_taken  = bus.ex_pred_taken;
    assign bus4.ex_pred_target = bus.ex_pred_target;
    assign bus4.btb_flush      = bus.btb_flush;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    bit          m_valid [N];
    logic [31:0] m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];
    logic        m_mp;
    logic [31:0] m_redir;
    int          m_br, m_mpc, m_br4, m_mpc4;

    typedef struct {
        logic [31:0] fpc;
        logic        ev;
        logic [31:0] epc;
        logic [12:0] imm;
        logic [2:0]  f3;
        logic [3:0]  znvc;
        logic        pt;
        logic [31:0] ptgt;
        logic        fl;
        logic        e_pt;
        logic [31:0] e_ptgt;
        logic        e_mp;
        logic [31:0] e_red;
    } vec_t;
    vec_t vt [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 32'd4) % 32'(N));
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc / (32'd4 * 32'(N));
    endfunction

    task automatic lookup(input logic [31:0] pc, output logic tk, output logic [31:0] tgt);
        int i;
        i   = idx_of(pc);
        tk  = m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
        tgt = tk ? m_tgt[i] : pc + 32'd4;
    endtask

    task automatic drive(input logic [31:0] fpc, input logic ev, input logic [31:0] epc,
                         input logic [12:0] imm, input logic [2:0] f3, input logic [3:0] znvc,
                         input logic pt, input logic [31:0] ptgt, input logic fl);
        bus.fetch_pc       = fpc;
        bus.ex_valid       = ev;
        bus.ex_pc          = epc;
        bus.ex_imm         = imm;
        bus.ex_func3       = f3;
        {bus.z, bus.n, bus.v, bus.c} = znvc;
        bus.ex_pred_taken  = pt;
        bus.ex_pred_target = ptgt;
        bus.btb_flush      = fl;
    endtask

    // checks prediction, applies one clock edge to DUT and model, checks registered outputs
    task automatic step(input bit chk_pred);
        logic        ptk, tk, legal, mp;
        logic [31:0] ptgt, tgt, nxt;
        int          off, j;
        #1;
        lookup(bus.fetch_pc, ptk, ptgt);
        if (chk_pred) begin
            chk("pred_taken", 64'(bus.pred_taken), 64'(ptk));
            chk("pred_target", 64'(bus.pred_target), 64'(ptgt));
        end
        legal = 1'b1;
        case (bus.ex_func3)
            3'd0:    tk = bus.z;
            3'd1:    tk = !bus.z;
            3'd4:    tk = (bus.n != bus.v);
            3'd5:    tk = (bus.n == bus.v);
            3'd6:    tk = !bus.c;
            3'd7:    tk = bus.c;
            default: begin tk = 1'b0; legal = 1'b0; end
        endcase
        off = int'(bus.ex_imm & 13'h1FFE);
        if (off >= 4096) off = off - 8192;
        tgt = bus.ex_pc + 32'(off);
        nxt = tk ? tgt : bus.ex_pc + 32'd4;
        mp  = bus.ex_valid && ((tk != bus.ex_pred_taken) || (tk && (bus.ex_pred_target != tgt)));
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_valid[i] = 1'b0;
                m_ctr[i]   = 1;
            end
            m_mp = 1'b0; m_redir = 32'd0;
            m_br = 0; m_mpc = 0; m_br4 = 0; m_mpc4 = 0;
        end else begin
            if (bus.btb_flush) begin
                for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
            end else if (bus.ex_valid && legal) begin
                j = idx_of(bus.ex_pc);
                if (m_valid[j] && (m_tag[j] == tag_of(bus.ex_pc))) begin
                    if (tk) begin
                        m_ctr[j] = (m_ctr[j] < 3) ? m_ctr[j] + 1 : 3;
                        m_tgt[j] = tgt;
                    end else begin
                        m_ctr[j] = (m_ctr[j] > 0) ? m_ctr[j] - 1 : 0;
                    end
                end else if (tk) begin
                    m_valid[j] = 1'b1;
                    m_tag[j]   = tag_of(bus.ex_pc);
                    m_tgt[j]   = tgt;
                    m_ctr[j]   = 2;
                end
            end
            m_mp = mp;
            if (mp) m_redir = nxt;
            if (bus.ex_valid) begin
                if (m_br < 65535) m_br++;
                if (m_br4 < 15) m_br4++;
            end
            if (mp) begin
                if (m_mpc < 65535) m_mpc++;
                if (m_mpc4 < 15) m_mpc4++;
            end
        end
        #1;
        chk("mispredict", 64'(bus.mispredict), 64'(m_mp));
        chk("redirect_pc", 64'(bus.redirect_pc), 64'(m_redir));
        chk("br_count", 64'(bus.br_count), 64'(m_br));
        chk("mp_count", 64'(bus.mp_count), 64'(m_mpc));
        chk("br_count_w4", 64'(bus4.br_count), 64'(m_br4));
        chk("mp_count_w4", 64'(bus4.mp_count), 64'(m_mpc4));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        pt, ev, fl;
        logic [31:0] ptgt, epc, fpc;
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0; m_ctr[i] = 1; m_tag[i] = 32'd0; m_tgt[i] = 32'd0;
        end
        m_mp = 1'b0; m_redir = 32'd0; m_br = 0; m_mpc = 0; m_br4 = 0; m_mpc4 = 0;

        //           fpc       ev    epc       imm       f3    znvc     pt    ptgt      fl      e_pt  e_ptgt    e_mp  e_red
        vt[0]  = '{32'h100, 1'b1, 32'h100, 13'h0008, 3'd0, 4'b1000, 1'b0, 32'h000, 1'b0,  1'b0, 32'h104, 1'b1, 32'h108};
        vt[1]  = '{32'h100, 1'b1, 32'h100, 13'h0008, 3'd0, 4'b1000, 1'b1, 32'h108, 1'b0,  1'b1, 32'h108, 1'b0, 32'h108};
        vt[2]  = '{32'h100, 1'b1, 32'h100, 13'h0008, 3'd0, 4'b1000, 1'b1, 32'h108, 1'b0,  1'b1, 32'h108, 1'b0, 32'h108};
        vt[3]  = '{32'h200, 1'b1, 32'h200, 13'h1FF0, 3'd4, 4'b0100, 1'b0, 32'h000, 1'b0,  1'b0, 32'h204, 1'b1, 32'h1F0};
        vt[4]  = '{32'h300, 1'b1, 32'h200, 13'h1FF0, 3'd4, 4'b0110, 1'b0, 32'h000, 1'b0,  1'b0, 32'h304, 1'b0, 32'h1F0};
        vt[5]  = '{32'h140, 1'b1, 32'h100, 13'h0008, 3'd0, 4'b1000, 1'b1, 32'h108, 1'b0,  1'b0, 32'h144, 1'b0, 32'h1F0};
        vt[6]  = '{32'h100, 1'b1, 32'h140, 13'h0008, 3'd0, 4'b1000, 1'b0, 32'h000, 1'b0,  1'b1, 32'h108, 1'b1, 32'h148};
        vt[7]  = '{32'h100, 1'b0, 32'h000, 13'h0000, 3'd0, 4'b0000, 1'b0, 32'h000, 1'b0,  1'b0, 32'h104, 1'b0, 32'h148};
        vt[8]  = '{32'h140, 1'b0, 32'h000, 13'h0000, 3'd0, 4'b0000, 1'b0, 32'h000, 1'b1,  1'b1, 32'h148, 1'b0, 32'h148};
        vt[9]  = '{32'h140, 1'b0, 32'h000, 13'h0000, 3'd0, 4'b0000, 1'b0, 32'h000, 1'b0,  1'b0, 32'h144, 1'b0, 32'h148};
        vt[10] = '{32'h400, 1'b1, 32'h400, 13'h0008, 3'd2, 4'b1000, 1'b1, 32'h408, 1'b0,  1'b0, 32'h404, 1'b1, 32'h404};
        vt[11] = '{32'h400, 1'b0, 32'h000, 13'h0000, 3'd0, 4'b0000, 1'b0, 32'h000, 1'b0,  1'b0, 32'h404, 1'b0, 32'h404};

        // reset
        drive(32'h0, 1'b0, 32'h0, 13'h0, 3'd0, 4'b0, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        step(1'b0);
        @(negedge clk);
        step(1'b1);
        @(negedge clk);
        rst = 1'b0;

        // directed vector table
        for (int k = 0; k < 12; k++) begin
            drive(vt[k].fpc, vt[k].ev, vt[k].epc, vt[k].imm, vt[k].f3, vt[k].znvc,
                  vt[k].pt, vt[k].ptgt, vt[k].fl);
            #1;
            chk($sformatf("vec%0d_pred_taken", k), 64'(bus.pred_taken), 64'(vt[k].e_pt));
            chk($sformatf("vec%0d_pred_target", k), 64'(bus.pred_target), 64'(vt[k].e_ptgt));
            step(1'b1);
            chk($sformatf("vec%0d_mispredict", k), 64'(bus.mispredict), 64'(vt[k].e_mp));
            chk($sformatf("vec%0d_redirect", k), 64'(bus.redirect_pc), 64'(vt[k].e_red));
            @(negedge clk);
        end

        // perf saturation: reset then 20 mispredicting not-taken branches
        rst = 1'b1;
        drive(32'h0, 1'b0, 32'h0, 13'h0, 3'd0, 4'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            drive(32'h800, 1'b1, 32'h800 + 32'(k * 4), 13'h0010, 3'd0, 4'b0000, 1'b1, 32'h810, 1'b0);
            step(1'b1);
            @(negedge clk);
        end
        chk("sat_br_count_w16", 64'(bus.br_count), 64'd20);
        chk("sat_mp_count_w16", 64'(bus.mp_count), 64'd20);
        chk("sat_br_count_w4", 64'(bus4.br_count), 64'd15);
        chk("sat_mp_count_w4", 64'(bus4.mp_count), 64'd15);

        // reset while a redirect is pending drops it
        drive(32'h900, 1'b1, 32'h900, 13'h0020, 3'd1, 4'b0000, 1'b0, 32'h0, 1'b0);
        step(1'b1);
        chk("pre_rst_mispredict", 64'(bus.mispredict), 64'd1);
        chk("pre_rst_redirect", 64'(bus.redirect_pc), 64'h920);
        @(negedge clk);
        rst = 1'b1;
        step(1'b1);
        chk("rst_drops_redirect", 64'(bus.mispredict), 64'd0);
        chk("rst_clears_redirect_pc", 64'(bus.redirect_pc), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // random traffic against the model
        for (int it = 0; it < 500; it++) begin
            epc = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
            if ($urandom_range(0, 7) == 0) epc[31:24] = 8'hFF;
            if ($urandom_range(0, 1) == 1) begin
                fpc = epc;
            end else begin
                fpc = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
            end
            lookup(epc, pt, ptgt);
            if ($urandom_range(0, 3) == 0) begin
                pt   = 1'($urandom);
                ptgt = ($urandom_range(0, 1) == 1) ? ptgt : 32'($urandom) & 32'hFFFF_FFFE;
            end
            ev  = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 31) == 0);
            rst = ($urandom_range(0, 63) == 0);
            drive(fpc, ev, epc, 13'($urandom), 3'($urandom), 4'($urandom), pt, ptgt, fl);
            step(1'b1);
            @(negedge clk);
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
